// File: rtl/mcu_lsu.sv
// Load/store unit: one outstanding request, alignment check, lane steering,
// load sign/zero extension and a bounded wait for mem_ready.
module mcu_lsu #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_fault,
    output logic [1:0]        resp_fault_code,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [3:0]        mem_strb,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic              busy
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = 4;
    localparam int unsigned CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    localparam logic [1:0] FC_NONE    = 2'b00;
    localparam logic [1:0] FC_ALIGN   = 2'b01;
    localparam logic [1:0] FC_TIMEOUT = 2'b10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               write_q, write_d;
    logic [1:0]         size_q, size_d;
    logic               unsigned_q, unsigned_d;
    logic [1:0]         offset_q, offset_d;
    logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;

    logic               req_ready_d;
    logic               busy_d;
    logic               resp_valid_d;
    logic [DATA_W-1:0]  resp_rdata_d;
    logic               resp_fault_d;
    logic [1:0]         resp_fault_code_d;
    logic [ADDR_W-1:0]  mem_addr_d;
    logic [DATA_W-1:0]  mem_wdata_d;
    logic               mem_read_d;
    logic               mem_write_d;
    logic [STRB_W-1:0]  mem_strb_d;

    logic               misalign_c;
    logic [STRB_W-1:0]  store_strb_c;
    logic [DATA_W-1:0]  store_data_c;
    logic [DATA_W-1:0]  shifted_c;
    logic [DATA_W-1:0]  load_data_c;
    logic               timeout_hit_c;

    // Request decode: alignment, byte strobes and lane-replicated store data
    always_comb begin
        misalign_c   = 1'b0;
        store_strb_c = 4'b1111;
        store_data_c = req_wdata;
        case (req_size)
            SIZE_BYTE: begin
                store_strb_c = 4'b0001 << req_addr[1:0];
                store_data_c = {4{req_wdata[7:0]}};
            end
            SIZE_HALF: begin
                misalign_c   = req_addr[0];
                store_strb_c = 4'b0011 << req_addr[1:0];
                store_data_c = {2{req_wdata[15:0]}};
            end
            SIZE_WORD: begin
                misalign_c   = (req_addr[1:0] != 2'b00);
            end
            default: begin
                misalign_c   = 1'b1;
            end
        endcase
    end

    // Load data: shift the addressed lane down, then extend to 32 bits
    always_comb begin
        shifted_c = mem_rdata >> {offset_q, 3'b000};
        case (size_q)
            SIZE_BYTE: load_data_c = unsigned_q ? {24'd0, shifted_c[7:0]}
                                                : {{24{shifted_c[7]}}, shifted_c[7:0]};
            SIZE_HALF: load_data_c = unsigned_q ? {16'd0, shifted_c[15:0]}
                                                : {{16{shifted_c[15]}}, shifted_c[15:0]};
            default:   load_data_c = shifted_c;
        endcase
    end

    // This cycle is the TIMEOUT-th ACCESS cycle without mem_ready
    assign timeout_hit_c = (TIMEOUT != 0) && ((32'(wait_cnt_q) + 32'd1) >= TIMEOUT);

    // Next-state and next-output logic
    always_comb begin
        state_d           = state_q;
        write_d           = write_q;
        size_d            = size_q;
        unsigned_d        = unsigned_q;
        offset_d          = offset_q;
        wait_cnt_d        = wait_cnt_q;
        req_ready_d       = 1'b0;
        busy_d            = 1'b1;
        resp_valid_d      = 1'b0;
        resp_rdata_d      = '0;
        resp_fault_d      = 1'b0;
        resp_fault_code_d = FC_NONE;
        mem_addr_d        = '0;
        mem_wdata_d       = '0;
        mem_read_d        = 1'b0;
        mem_write_d       = 1'b0;
        mem_strb_d        = '0;

        case (state_q)
            IDLE: begin
                req_ready_d = 1'b1;
                busy_d      = 1'b0;
                if (req_valid && req_ready) begin
                    write_d     = req_write;
                    size_d      = req_size;
                    unsigned_d  = req_unsigned;
                    offset_d    = req_addr[1:0];
                    req_ready_d = 1'b0;
                    busy_d      = 1'b1;
                    if (misalign_c) begin
                        state_d           = RESP;
                        resp_valid_d      = 1'b1;
                        resp_fault_d      = 1'b1;
                        resp_fault_code_d = FC_ALIGN;
                    end else begin
                        state_d     = ACCESS;
                        wait_cnt_d  = '0;
                        mem_read_d  = ~req_write;
                        mem_write_d = req_write;
                        mem_addr_d  = {req_addr[ADDR_W-1:2], 2'b00};
                        mem_wdata_d = store_data_c;
                        mem_strb_d  = req_write ? store_strb_c : 4'b1111;
                    end
                end
            end
            ACCESS: begin
                if (mem_ready) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = write_q ? '0 : load_data_c;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                    if (timeout_hit_c) begin
                        state_d           = RESP;
                        resp_valid_d      = 1'b1;
                        resp_fault_d      = 1'b1;
                        resp_fault_code_d = FC_TIMEOUT;
                    end else begin
                        mem_read_d  = mem_read;
                        mem_write_d = mem_write;
                        mem_addr_d  = mem_addr;
                        mem_wdata_d = mem_wdata;
                        mem_strb_d  = mem_strb;
                    end
                end
            end
            RESP: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
                busy_d      = 1'b0;
            end
            default: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
                busy_d      = 1'b0;
            end
        endcase
    end

    // State, captured request and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            write_q         <= 1'b0;
            size_q          <= 2'b00;
            unsigned_q      <= 1'b0;
            offset_q        <= 2'b00;
            wait_cnt_q      <= '0;
            req_ready       <= 1'b1;
            busy            <= 1'b0;
            resp_valid      <= 1'b0;
            resp_rdata      <= '0;
            resp_fault      <= 1'b0;
            resp_fault_code <= FC_NONE;
            mem_addr        <= '0;
            mem_wdata       <= '0;
            mem_read        <= 1'b0;
            mem_write       <= 1'b0;
            mem_strb        <= '0;
        end else begin
            state_q         <= state_d;
            write_q         <= write_d;
            size_q          <= size_d;
            unsigned_q      <= unsigned_d;
            offset_q        <= offset_d;
            wait_cnt_q      <= wait_cnt_d;
            req_ready       <= req_ready_d;
            busy            <= busy_d;
            resp_valid      <= resp_valid_d;
            resp_rdata      <= resp_rdata_d;
            resp_fault      <= resp_fault_d;
            resp_fault_code <= resp_fault_code_d;
            mem_addr        <= mem_addr_d;
            mem_wdata       <= mem_wdata_d;
            mem_read        <= mem_read_d;
            mem_write       <= mem_write_d;
            mem_strb        <= mem_strb_d;
        end
    end

endmodule

// File: tb/tb_mcu_lsu.sv
// Self-checking bench for mcu_lsu: directed vector table, multi-cycle
// sequences (reset mid-access, back-to-back) and randomized transactions.
module tb_mcu_lsu;

    localparam int unsigned TMO = 4;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic [1:0]  resp_fault_code;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_read;
    logic        mem_write;
    logic [3:0]  mem_strb;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    mcu_lsu #(.ADDR_W(32), .TIMEOUT(TMO)) dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_write       (req_write),
        .req_size        (req_size),
        .req_unsigned    (req_unsigned),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .resp_valid      (resp_valid),
        .resp_rdata      (resp_rdata),
        .resp_fault      (resp_fault),
        .resp_fault_code (resp_fault_code),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_strb        (mem_strb),
        .mem_rdata       (mem_rdata),
        .mem_ready       (mem_ready),
        .busy            (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        wr;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rd;
        int unsigned dly;
        logic [31:0] e_rdata;
        logic        e_fault;
        logic [1:0]  e_code;
        logic [31:0] e_maddr;
        logic [3:0]  e_strb;
        logic [31:0] e_mwdata;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model computed from the access rules with plain arithmetic
    task automatic model(input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd,
                         input int unsigned dly,
                         output logic [31:0] e_rdata, output logic e_fault, output logic [1:0] e_code,
                         output logic [31:0] e_maddr, output logic [3:0] e_strb,
                         output logic [31:0] e_mwdata);
        int nb;
        int off;
        longint v;
        longint span;
        nb  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        off = int'(addr % 32'd4);
        e_maddr = addr - 32'(off);
        e_strb  = wr ? 4'(((1 << nb) - 1) << off) : 4'hF;
        for (int i = 0; i < 4; i++) e_mwdata[8*i +: 8] = wd[8*(i % nb) +: 8];
        e_rdata = 32'd0;
        e_fault = 1'b0;
        e_code  = 2'd0;
        if (sz == 2'd3 || (off % nb) != 0) begin
            e_fault = 1'b1;
            e_code  = 2'd1;
        end else if (dly >= TMO) begin
            e_fault = 1'b1;
            e_code  = 2'd2;
        end else if (!wr) begin
            span = longint'(1) << (8 * nb);
            v = longint'(rd >> (8 * off)) % span;
            if (!uns && v >= span / 2) v = v - span;
            e_rdata = 32'(v);
        end
    endtask

    // One full transaction, checked every cycle; called at a negedge with the DUT idle
    task automatic do_txn(input string name, input logic wr, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd,
                          input int unsigned dly,
                          input logic [31:0] e_rdata, input logic e_fault, input logic [1:0] e_code,
                          input logic [31:0] e_maddr, input logic [3:0] e_strb,
                          input logic [31:0] e_mwdata);
        int unsigned acc_len;
        bit mis;
        mis = e_fault && (e_code == 2'd1);
        if (mis) acc_len = 0;
        else if (e_fault) acc_len = TMO;
        else acc_len = dly + 1;

        chk({name, ".idle_ready"}, 32'(req_ready), 32'd1);
        req_valid    = 1'b1;
        req_write    = wr;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wd;
        mem_ready    = 1'($urandom_range(0, 1));
        mem_rdata    = $urandom;
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_size  = 2'($urandom_range(0, 3));
        req_write = 1'($urandom_range(0, 1));

        for (int unsigned k = 1; k <= acc_len; k++) begin
            chk($sformatf("%s.c%0d.mem_read", name, k), 32'(mem_read), 32'(!wr));
            chk($sformatf("%s.c%0d.mem_write", name, k), 32'(mem_write), 32'(wr));
            chk($sformatf("%s.c%0d.mem_addr", name, k), mem_addr, e_maddr);
            chk($sformatf("%s.c%0d.mem_strb", name, k), 32'(mem_strb), 32'(e_strb));
            if (wr) chk($sformatf("%s.c%0d.mem_wdata", name, k), mem_wdata, e_mwdata);
            chk($sformatf("%s.c%0d.resp_valid", name, k), 32'(resp_valid), 32'd0);
            chk($sformatf("%s.c%0d.req_ready", name, k), 32'(req_ready), 32'd0);
            chk($sformatf("%s.c%0d.busy", name, k), 32'(busy), 32'd1);
            if (k == dly + 1) begin
                mem_ready = 1'b1;
                mem_rdata = rd;
            end else begin
                mem_ready = 1'b0;
                mem_rdata = $urandom;
            end
            @(negedge clk);
        end
        mem_ready = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;

        chk({name, ".resp_valid"}, 32'(resp_valid), 32'd1);
        chk({name, ".resp_rdata"}, resp_rdata, e_rdata);
        chk({name, ".resp_fault"}, 32'(resp_fault), 32'(e_fault));
        chk({name, ".fault_code"}, 32'(resp_fault_code), 32'(e_code));
        chk({name, ".resp_mem_rw"}, {30'd0, mem_read, mem_write}, 32'd0);
        chk({name, ".resp_busy"}, 32'(busy), 32'd1);
        @(negedge clk);
        chk({name, ".post_valid"}, 32'(resp_valid), 32'd0);
        chk({name, ".post_rdata"}, resp_rdata, 32'd0);
        chk({name, ".post_fault"}, {29'd0, resp_fault, resp_fault_code}, 32'd0);
        chk({name, ".post_busy"}, 32'(busy), 32'd0);
        mem_ready = 1'b0;
    endtask

    initial begin
        logic        r_wr;
        logic [1:0]  r_sz;
        logic        r_uns;
        logic [31:0] r_addr, r_wd, r_rd;
        int unsigned r_dly;
        logic [31:0] m_rdata, m_maddr, m_mwdata;
        logic        m_fault;
        logic [1:0]  m_code;
        logic [3:0]  m_strb;

        //           wr    sz     uns   addr          wdata         mem_rdata     dly  rdata         flt   code   maddr         strb     mwdata
        vecs[0]  = '{1'b0, 2'd0, 1'b0, 32'h0000_0103, 32'h0,        32'h80FF_1234, 0, 32'hFFFF_FF80, 1'b0, 2'd0, 32'h0000_0100, 4'hF,   32'h0};
        vecs[1]  = '{1'b1, 2'd1, 1'b0, 32'h0000_0022, 32'h0000_ABCD, 32'h0,        2, 32'h0,         1'b0, 2'd0, 32'h0000_0020, 4'b1100, 32'hABCD_ABCD};
        vecs[2]  = '{1'b0, 2'd2, 1'b0, 32'h0000_0041, 32'h0,        32'h0,         0, 32'h0,         1'b1, 2'd1, 32'h0,         4'h0,   32'h0};
        vecs[3]  = '{1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'h0,        32'h1111_2222, 9, 32'h0,         1'b1, 2'd2, 32'h0000_0010, 4'hF,   32'h0};
        vecs[4]  = '{1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'h0,        32'hDEAD_BEEF, 3, 32'hDEAD_BEEF, 1'b0, 2'd0, 32'h0000_0010, 4'hF,   32'h0};
        vecs[5]  = '{1'b0, 2'd1, 1'b1, 32'h0000_0002, 32'h0,        32'hFFFF_0000, 0, 32'h0000_FFFF, 1'b0, 2'd0, 32'h0000_0000, 4'hF,   32'h0};
        vecs[6]  = '{1'b0, 2'd1, 1'b0, 32'h0000_0002, 32'h0,        32'h8001_0000, 1, 32'hFFFF_8001, 1'b0, 2'd0, 32'h0000_0000, 4'hF,   32'h0};
        vecs[7]  = '{1'b1, 2'd0, 1'b0, 32'h0000_0001, 32'h1234_565A, 32'h0,        0, 32'h0,         1'b0, 2'd0, 32'h0000_0000, 4'b0010, 32'h5A5A_5A5A};
        vecs[8]  = '{1'b1, 2'd2, 1'b0, 32'h0000_0004, 32'h1234_5678, 32'h0,        2, 32'h0,         1'b0, 2'd0, 32'h0000_0004, 4'hF,   32'h1234_5678};
        vecs[9]  = '{1'b0, 2'd3, 1'b0, 32'h0000_0000, 32'h0,        32'h0,         0, 32'h0,         1'b1, 2'd1, 32'h0,         4'h0,   32'h0};
        vecs[10] = '{1'b0, 2'd1, 1'b0, 32'h0000_0001, 32'h0,        32'h0,         0, 32'h0,         1'b1, 2'd1, 32'h0,         4'h0,   32'h0};
        vecs[11] = '{1'b0, 2'd0, 1'b1, 32'h0000_0302, 32'h0,        32'h00AB_0000, 1, 32'h0000_00AB, 1'b0, 2'd0, 32'h0000_0300, 4'hF,   32'h0};

        reset        = 1'b1;
        req_valid    = 1'b0;
        req_write    = 1'b0;
        req_size     = 2'd0;
        req_unsigned = 1'b0;
        req_addr     = 32'd0;
        req_wdata    = 32'd0;
        mem_rdata    = 32'd0;
        mem_ready    = 1'b0;
        repeat (3) @(negedge clk);

        // Outputs held in reset
        chk("rst.req_ready", 32'(req_ready), 32'd1);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.resp", {28'd0, resp_valid, resp_fault, resp_fault_code}, 32'd0);
        chk("rst.resp_rdata", resp_rdata, 32'd0);
        chk("rst.mem_ctl", {26'd0, mem_read, mem_write, mem_strb}, 32'd0);
        chk("rst.mem_addr", mem_addr, 32'd0);
        chk("rst.mem_wdata", mem_wdata, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            do_txn($sformatf("vec%0d", i), vecs[i].wr, vecs[i].sz, vecs[i].uns, vecs[i].addr,
                   vecs[i].wd, vecs[i].rd, vecs[i].dly, vecs[i].e_rdata, vecs[i].e_fault,
                   vecs[i].e_code, vecs[i].e_maddr, vecs[i].e_strb, vecs[i].e_mwdata);
        end

        // Reset asserted while ACCESS waits for mem_ready
        req_valid    = 1'b1;
        req_write    = 1'b0;
        req_size     = 2'd2;
        req_unsigned = 1'b0;
        req_addr     = 32'h0000_0080;
        mem_ready    = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        chk("rstmid.mem_read_before", 32'(mem_read), 32'd1);
        @(negedge clk);
        chk("rstmid.mem_read_wait", 32'(mem_read), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("rstmid.mem_read_drop", 32'(mem_read), 32'd0);
        chk("rstmid.req_ready", 32'(req_ready), 32'd1);
        chk("rstmid.busy", 32'(busy), 32'd0);
        chk("rstmid.mem_addr", mem_addr, 32'd0);
        @(negedge clk);
        reset     = 1'b0;
        mem_ready = 1'b1;
        mem_rdata = 32'hCAFE_F00D;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rstmid.after%0d.resp_valid", k), 32'(resp_valid), 32'd0);
            chk($sformatf("rstmid.after%0d.req_ready", k), 32'(req_ready), 32'd1);
            chk($sformatf("rstmid.after%0d.mem_read", k), 32'(mem_read), 32'd0);
            @(negedge clk);
        end
        mem_ready = 1'b0;

        // Back-to-back: req_valid held, memory always ready, one acceptance per 3 cycles
        req_valid    = 1'b1;
        req_write    = 1'b0;
        req_size     = 2'd1;
        req_unsigned = 1'b1;
        req_addr     = 32'h0000_0002;
        mem_ready    = 1'b1;
        mem_rdata    = 32'hFFFF_0000;
        for (int c = 0; c < 9; c++) begin
            chk($sformatf("b2b.c%0d.req_ready", c), 32'(req_ready), 32'((c % 3) == 0));
            chk($sformatf("b2b.c%0d.resp_valid", c), 32'(resp_valid), 32'((c % 3) == 2));
            chk($sformatf("b2b.c%0d.resp_rdata", c), resp_rdata,
                ((c % 3) == 2) ? 32'h0000_FFFF : 32'd0);
            chk($sformatf("b2b.c%0d.mem_read", c), 32'(mem_read), 32'((c % 3) == 1));
            @(negedge clk);
        end
        req_valid = 1'b0;
        mem_ready = 1'b0;
        chk("b2b.end.req_ready", 32'(req_ready), 32'd1);

        // Randomized transactions against the reference model
        for (int i = 0; i < 60; i++) begin
            r_wr   = 1'($urandom_range(0, 1));
            r_sz   = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            r_uns  = 1'($urandom_range(0, 1));
            r_addr = $urandom & 32'h0000_0FFF;
            if ($urandom_range(0, 2) != 0) begin
                if (r_sz == 2'd1) r_addr[0] = 1'b0;
                if (r_sz == 2'd2) r_addr[1:0] = 2'b00;
            end
            r_wd  = $urandom;
            r_rd  = $urandom;
            r_dly = $urandom_range(0, 5);
            model(r_wr, r_sz, r_uns, r_addr, r_wd, r_rd, r_dly,
                  m_rdata, m_fault, m_code, m_maddr, m_strb, m_mwdata);
            do_txn($sformatf("rnd%0d", i), r_wr, r_sz, r_uns, r_addr, r_wd, r_rd, r_dly,
                   m_rdata, m_fault, m_code, m_maddr, m_strb, m_mwdata);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
